// File: rtl/accelbrot_com_pkg.sv
// Shared definitions for the accelbrot com link transmit path.
//
// Contents:
//   tx_state_e      - frame packer FSM states
//   SofByteDefault  - default start-of-frame marker byte
//   csum_byte()     - turns a running byte sum into the closing checksum byte
package accelbrot_com_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StLen,
        StPayload,
        StCsum
    } tx_state_e;

    localparam logic [7:0] SofByteDefault = 8'hA5;

    // Two's complement of the sum so that sum + csum == 0 (mod 256).
    function automatic logic [7:0] csum_byte(input logic [7:0] sum);
        return 8'h00 - sum;
    endfunction

endpackage

// File: rtl/accelbrot_com_tx_byte_reg.sv
// Single-entry valid/ready output register for the com byte stream.
//
// The packer pushes a byte whenever can_load is high; the byte is then held
// on tx_data with tx_valid high until the link accepts it. A cycle with
// can_load high and push low empties the register (tx_valid drops).
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - load push_data this cycle (only honoured while can_load)
//   push_data   - byte to load
//   can_load    - register is empty or its byte is being accepted now
//   tx_valid    - registered byte valid towards the link
//   tx_ready    - link accepts the byte
//   tx_data     - registered byte
module accelbrot_com_tx_byte_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       can_load,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    assign can_load = !valid_q || tx_ready;
    assign tx_valid = valid_q;
    assign tx_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (can_load) begin
            valid_d = push;
            // Keep the old byte when emptying so tx_data does not toggle needlessly.
            if (push) begin
                data_d = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/accelbrot_com_tx_packer.sv
// Frame packer for the accelbrot com link transmitter.
//
// On a command it emits one frame on the byte stream:
//   SOF_BYTE, L, payload bytes (L words, LSB byte first), checksum
// where L = min(cmd_len, MAX_WORDS) and the checksum makes
// (L + payload bytes + checksum) mod 256 == 0.
//
// The FSM state names the kind of byte currently held in the output
// register. Payload words are pulled from a FIFO read port into a shift
// register; the next byte is always prepared in the same cycle the current
// one is accepted, so with everything ready the stream has no bubbles.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cmd_valid/ready/len   - frame request and its word count
//   in_valid/ready/data   - payload words (FIFO read side)
//   tx_valid/ready/data   - byte stream to the link
//   busy                  - a frame is in progress
module accelbrot_com_tx_packer
    import accelbrot_com_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 16,
    parameter logic [7:0]  SOF_BYTE   = SofByteDefault
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   cmd_len,

    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,

    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [7:0]                       tx_data,

    output logic                             busy
);

    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam int unsigned LenW  = $clog2(MAX_WORDS + 1);
    localparam int unsigned CntW  = $clog2(Bytes + 1);

    tx_state_e             state_q, state_d;
    logic [LenW-1:0]       len_q, len_d;        // effective frame length L
    logic [LenW-1:0]       words_q, words_d;    // payload words not yet loaded
    logic [DATA_WIDTH-1:0] sr_q, sr_d;          // remaining bytes of current word
    logic [CntW-1:0]       sr_cnt_q, sr_cnt_d;  // bytes left in sr_q
    logic [7:0]            sum_q, sum_d;        // L + payload bytes loaded so far

    logic                  can_load;
    logic                  push;
    logic [7:0]            push_data;
    logic [LenW-1:0]       eff_len;

    assign eff_len   = (cmd_len > LenW'(MAX_WORDS)) ? LenW'(MAX_WORDS) : cmd_len;
    assign busy      = (state_q != StIdle);
    assign cmd_ready = (state_q == StIdle);

    // A new word may enter only when the shift register is drained and the
    // output register is free (or freeing up) to take its first byte.
    assign in_ready = !rst
                      && ((state_q == StLen) || (state_q == StPayload))
                      && (words_q != '0)
                      && (sr_cnt_q == '0)
                      && can_load;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        words_d   = words_q;
        sr_d      = sr_q;
        sr_cnt_d  = sr_cnt_q;
        sum_d     = sum_q;
        push      = 1'b0;
        push_data = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    push      = 1'b1;
                    push_data = SOF_BYTE;
                    len_d     = eff_len;
                    words_d   = eff_len;
                    sum_d     = 8'(eff_len);
                    state_d   = StSof;
                end
            end

            StSof: begin
                if (can_load) begin
                    push      = 1'b1;
                    push_data = 8'(len_q);
                    state_d   = StLen;
                end
            end

            StLen: begin
                if (can_load) begin
                    if (len_q == '0) begin
                        push      = 1'b1;
                        push_data = csum_byte(sum_q);
                        state_d   = StCsum;
                    end else begin
                        state_d = StPayload;
                        if (in_valid && in_ready) begin
                            push      = 1'b1;
                            push_data = in_data[7:0];
                            sr_d      = in_data >> 8;
                            sr_cnt_d  = CntW'(Bytes - 1);
                            words_d   = words_q - LenW'(1);
                            sum_d     = sum_q + in_data[7:0];
                        end
                    end
                end
            end

            StPayload: begin
                if (can_load) begin
                    if (sr_cnt_q != '0) begin
                        push      = 1'b1;
                        push_data = sr_q[7:0];
                        sr_d      = sr_q >> 8;
                        sr_cnt_d  = sr_cnt_q - CntW'(1);
                        sum_d     = sum_q + sr_q[7:0];
                    end else if (words_q != '0) begin
                        // No word available leaves the register empty: a bubble.
                        if (in_valid && in_ready) begin
                            push      = 1'b1;
                            push_data = in_data[7:0];
                            sr_d      = in_data >> 8;
                            sr_cnt_d  = CntW'(Bytes - 1);
                            words_d   = words_q - LenW'(1);
                            sum_d     = sum_q + in_data[7:0];
                        end
                    end else begin
                        // Last payload byte is being accepted; every payload
                        // byte is already in sum_q.
                        push      = 1'b1;
                        push_data = csum_byte(sum_q);
                        state_d   = StCsum;
                    end
                end
            end

            StCsum: begin
                if (can_load) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            words_q  <= '0;
            sr_q     <= '0;
            sr_cnt_q <= '0;
            sum_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            words_q  <= words_d;
            sr_q     <= sr_d;
            sr_cnt_q <= sr_cnt_d;
            sum_q    <= sum_d;
        end
    end

    accelbrot_com_tx_byte_reg u_byte_reg (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .can_load  (can_load),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data)
    );

endmodule

// File: tb/tb_accelbrot_com_tx_packer.sv
// Directed bench for accelbrot_com_tx_packer (DATA_WIDTH=32, MAX_WORDS=16).
module tb_accelbrot_com_tx_packer;

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 16;
    localparam int unsigned LW = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          busy;

    accelbrot_com_tx_packer #(
        .DATA_WIDTH (DW),
        .MAX_WORDS  (MW),
        .SOF_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] src [32];
    logic [7:0]    got [$];
    logic [7:0]    exp_q [$];
    int            words_taken;
    int            n_cycles;
    int            src_idx;
    logic          first_valid;
    bit            gap_seen;
    bit            unstable;
    bit            saw_in_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_seq(input string tag);
        check({tag, " byte count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s byte %0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
        end
    endtask

    // Starts at posedge+1 with the DUT idle; issues one command, then runs
    // until nbytes tx handshakes or a cycle budget. Returns at posedge+1.
    task automatic run_frame(input int len, input bit rnd, input int nbytes, input int base);
        bit         stalled;
        logic [7:0] held;
        stalled = 0;
        held = 8'h00;
        got.delete();
        words_taken = 0;
        n_cycles = 0;
        gap_seen = 0;
        unstable = 0;
        saw_in_ready = 0;
        src_idx = base;
        cmd_valid = 1'b1;
        cmd_len = LW'(len);
        tx_ready = 1'b0;
        in_valid = 1'b0;
        #1;
        check("cmd_ready idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        first_valid = tx_valid;
        for (int c = 0; c < 600 && got.size() < nbytes; c++) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = src[src_idx & 31];
            #1;
            if (stalled && (!tx_valid || tx_data !== held)) unstable = 1;
            if (in_ready) saw_in_ready = 1;
            if (!rnd && !tx_valid) gap_seen = 1;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (in_valid && in_ready) begin
                words_taken++;
                src_idx++;
            end
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            n_cycles++;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int n_cmd;
        int csum1_cyc;
        int sof2_cyc;
        int late_in;
        bit busy_cmd_ready;
        logic [7:0] sum;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;

        // One word, all ready: seven back-to-back bytes.
        src[0] = 32'h11223344;
        run_frame(1, 0, 7, 0);
        exp_q = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
        check_seq("len1");
        check("len1 first valid latency", first_valid, 1'b1);
        check("len1 cycles", n_cycles, 7);
        check("len1 no bubble", gap_seen, 1'b0);
        check("len1 words", words_taken, 1);
        check("len1 cmd_ready after", cmd_ready, 1'b1);
        check("len1 tx_valid after", tx_valid, 1'b0);

        // Empty frame.
        run_frame(0, 0, 3, 0);
        exp_q = '{8'hA5, 8'h00, 8'h00};
        check_seq("len0");
        check("len0 in_ready never", saw_in_ready, 1'b0);
        check("len0 busy after", busy, 1'b0);

        // Oversized request is clamped to MAX_WORDS.
        for (int i = 0; i < 32; i++) src[i] = {4{8'(i + 1)}};
        run_frame(20, 0, 67, 0);
        check("len20 LEN byte", got[1], 8'h10);
        check("len20 words", words_taken, 16);
        check("len20 csum byte", got[66], 8'hD0);
        sum = 8'h00;
        for (int i = 1; i < got.size(); i++) sum = sum + got[i];
        check("len20 csum total", sum, 8'h00);
        check("len20 no bubble", gap_seen, 1'b0);
        check("len20 cmd_ready after", cmd_ready, 1'b1);

        // Random backpressure and starvation.
        src[0] = 32'hDEADBEEF;
        src[1] = 32'h01234567;
        src[2] = 32'hCAFEF00D;
        run_frame(3, 1, 15, 0);
        exp_q = '{8'hA5, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
                  8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h30};
        check_seq("len3 rnd");
        check("len3 rnd stable", unstable, 1'b0);
        check("len3 rnd words", words_taken, 3);

        // Reset in the middle of a four-word payload.
        src[0] = 32'h10203040;
        src[1] = 32'h50607080;
        src[2] = 32'h90A0B0C0;
        src[3] = 32'hD0E0F000;
        src[4] = 32'hA1B2C3D4;
        run_frame(4, 0, 5, 0);
        check("abort in payload", busy, 1'b1);
        rst = 1'b1;
        tx_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort tx_valid", tx_valid, 1'b0);
        check("abort cmd_ready", cmd_ready, 1'b1);
        check("abort busy", busy, 1'b0);
        late_in = 0;
        for (int c = 0; c < 5; c++) begin
            if (in_valid && in_ready) late_in++;
            @(posedge clk);
            #2;
        end
        check("abort no in handshakes", late_in, 0);
        in_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1, 0, 7, 4);
        exp_q = '{8'hA5, 8'h01, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h15};
        check_seq("after abort");

        // Back-to-back commands with cmd_valid held high.
        src[0] = 32'h04030201;
        src[1] = 32'h08070605;
        src[2] = 32'h0C0B0A09;
        got.delete();
        src_idx = 0;
        n_cmd = 0;
        csum1_cyc = -1;
        sof2_cyc = -1;
        busy_cmd_ready = 0;
        cmd_valid = 1'b1;
        cmd_len = LW'(2);
        tx_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && got.size() < 18; c++) begin
            bit hs_cmd;
            in_data = src[src_idx & 31];
            #1;
            if (busy && cmd_ready) busy_cmd_ready = 1;
            hs_cmd = cmd_valid && cmd_ready;
            if (in_valid && in_ready) src_idx++;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (got.size() == 11) csum1_cyc = c;
                if (got.size() == 12) sof2_cyc = c;
            end
            @(posedge clk);
            #1;
            if (hs_cmd) begin
                n_cmd++;
                if (n_cmd == 1) cmd_len = LW'(1);
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hDA,
                  8'hA5, 8'h01, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hD5};
        check_seq("b2b");
        check("b2b sof after csum gap", sof2_cyc - csum1_cyc, 2);
        check("b2b cmd handshakes", n_cmd, 2);
        check("b2b cmd_ready while busy", busy_cmd_ready, 1'b0);
        check("b2b words", src_idx, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
